pcpu_core: RTL and testbench

// - Generalised pseudo-CPU core: P_NUM_REGS-entry register file, 8-op ALU, conditional branches.
// - Writable program memory of 2^P_LOG_MEMSIZE instructions and a start/busy/done handshake.
// - Optional watchdog step limit. Sits in place of the fixed two-register datapath/control pair.
// - Run model: r0/r1 loaded from arg_a/arg_b at start; result is r0 at HALT.

---
 rtl/pcpu_pkg.sv | 45 ++++
 rtl/pcpu_alu.sv | 32 +++
 rtl/pcpu_core.sv | 142 ++++++++++++++
 tb/tb_pcpu_core.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pcpu_pkg.sv
// Shared definitions for the pseudo-CPU core: opcodes, FSM states and
// instruction field slicing helpers parameterised by register/PC widths.
package pcpu_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SHR = 3'd5;
    localparam logic [2:0] OP_BLT = 3'd6;
    localparam logic [2:0] OP_BEQ = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Layout MSB first: {opc[2:0], rd, ra, rb, tgt}; rw = register index width, mw = PC width.
    function automatic logic [2:0] insn_opc(input logic [63:0] insn, input int unsigned rw,
                                            input int unsigned mw);
        return 3'(insn >> (3 * rw + mw));
    endfunction

    function automatic logic [63:0] insn_rd(input logic [63:0] insn, input int unsigned rw,
                                            input int unsigned mw);
        return (insn >> (2 * rw + mw)) & ((64'd1 << rw) - 64'd1);
    endfunction

    function automatic logic [63:0] insn_ra(input logic [63:0] insn, input int unsigned rw,
                                            input int unsigned mw);
        return (insn >> (rw + mw)) & ((64'd1 << rw) - 64'd1);
    endfunction

    function automatic logic [63:0] insn_rb(input logic [63:0] insn, input int unsigned rw,
                                            input int unsigned mw);
        return (insn >> mw) & ((64'd1 << rw) - 64'd1);
    endfunction

    function automatic logic [63:0] insn_tgt(input logic [63:0] insn, input int unsigned mw);
        return insn & ((64'd1 << mw) - 64'd1);
    endfunction

endpackage

// File: rtl/pcpu_alu.sv
// Combinational ALU for the pseudo-CPU: eight opcodes plus unsigned
// less-than and equality flags used by the branch instructions.
module pcpu_alu
    import pcpu_pkg::*;
#(
    parameter int unsigned P_WIDTH = 32
) (
    input  logic [2:0]         opc_i,
    input  logic [P_WIDTH-1:0] a_i,
    input  logic [P_WIDTH-1:0] b_i,
    output logic [P_WIDTH-1:0] result_o,
    output logic               lt_o,
    output logic               eq_o
);

    always_comb begin
        result_o = '0;
        case (opc_i)
            OP_ADD:  result_o = a_i + b_i;
            OP_SUB:  result_o = a_i - b_i;
            OP_AND:  result_o = a_i & b_i;
            OP_OR:   result_o = a_i | b_i;
            OP_XOR:  result_o = a_i ^ b_i;
            OP_SHR:  result_o = a_i >> 1;
            default: result_o = '0;
        endcase
    end

    assign lt_o = (a_i < b_i);
    assign eq_o = (a_i == b_i);

endmodule

// File: rtl/pcpu_core.sv
// Pseudo-CPU core: register file, writable program memory, PC, run FSM and
// watchdog. r0/r1 are loaded from the arguments; the result is r0 at HALT.
module pcpu_core
    import pcpu_pkg::*;
#(
    parameter int unsigned P_WIDTH       = 32,
    parameter int unsigned P_NUM_REGS    = 4,
    parameter int unsigned P_LOG_MEMSIZE = 4,
    parameter int unsigned P_MAX_STEPS   = 255
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic                                                  en,
    input  logic                                                  pm_we,
    input  logic [P_LOG_MEMSIZE-1:0]                              pm_addr,
    input  logic [3+3*$clog2(P_NUM_REGS)+P_LOG_MEMSIZE-1:0]       pm_wdata,
    input  logic                                                  start,
    input  logic [P_WIDTH-1:0]                                    arg_a,
    input  logic [P_WIDTH-1:0]                                    arg_b,
    output logic                                                  busy,
    output logic                                                  done,
    output logic                                                  err,
    output logic [P_WIDTH-1:0]                                    res
);

    localparam int unsigned RW = $clog2(P_NUM_REGS);
    localparam int unsigned IW = 3 + 3 * RW + P_LOG_MEMSIZE;

    state_e                   state_q, state_d;
    logic [P_WIDTH-1:0]       regs_q [P_NUM_REGS];
    logic [IW-1:0]            pm_q   [2**P_LOG_MEMSIZE];
    logic [P_LOG_MEMSIZE-1:0] pc_q;
    logic [31:0]              steps_q;
    logic                     err_q;
    logic [P_WIDTH-1:0]       res_q;

    logic [IW-1:0]            insn;
    logic [2:0]               opc;
    logic [RW-1:0]            rd, ra, rb;
    logic [P_LOG_MEMSIZE-1:0] tgt;
    logic [P_WIDTH-1:0]       alu_res;
    logic                     alu_lt, alu_eq;
    logic                     is_branch, taken, halt, wd_hit;

    assign insn = pm_q[pc_q];
    assign opc  = insn_opc(64'(insn), RW, P_LOG_MEMSIZE);
    assign rd   = RW'(insn_rd(64'(insn), RW, P_LOG_MEMSIZE));
    assign ra   = RW'(insn_ra(64'(insn), RW, P_LOG_MEMSIZE));
    assign rb   = RW'(insn_rb(64'(insn), RW, P_LOG_MEMSIZE));
    assign tgt  = P_LOG_MEMSIZE'(insn_tgt(64'(insn), P_LOG_MEMSIZE));

    pcpu_alu #(
        .P_WIDTH(P_WIDTH)
    ) u_alu (
        .opc_i   (opc),
        .a_i     (regs_q[ra]),
        .b_i     (regs_q[rb]),
        .result_o(alu_res),
        .lt_o    (alu_lt),
        .eq_o    (alu_eq)
    );

    assign is_branch = (opc == OP_BLT) || (opc == OP_BEQ);
    assign taken     = ((opc == OP_BLT) && alu_lt) || ((opc == OP_BEQ) && alu_eq);
    // A taken self-branch is the HALT idiom; it outranks the watchdog.
    assign halt      = (opc == OP_BEQ) && alu_eq && (tgt == pc_q);
    assign wd_hit    = (P_MAX_STEPS != 0) && (steps_q == 32'(P_MAX_STEPS));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else if (en) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (halt || wd_hit) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == ST_RUN);
        done = en && (state_q == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q  <= '{default: '0};
            pc_q    <= '0;
            steps_q <= '0;
            err_q   <= 1'b0;
            res_q   <= '0;
        end else if (en) begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        for (int unsigned i = 0; i < P_NUM_REGS; i++) begin
                            regs_q[RW'(i)] <= (i == 0) ? arg_a : (i == 1) ? arg_b : '0;
                        end
                        pc_q    <= '0;
                        steps_q <= '0;
                        err_q   <= 1'b0;
                        res_q   <= '0;
                    end
                end
                ST_RUN: begin
                    if (halt) begin
                        res_q <= regs_q[0];
                    end else if (wd_hit) begin
                        err_q <= 1'b1;
                        res_q <= regs_q[0];
                    end else begin
                        steps_q <= steps_q + 32'd1;
                        if (is_branch) begin
                            pc_q <= taken ? tgt : pc_q + 1'b1;
                        end else begin
                            regs_q[rd] <= alu_res;
                            pc_q       <= pc_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (en && pm_we && (state_q == ST_IDLE)) begin
            pm_q[pm_addr] <= pm_wdata;
        end
    end

    assign err = err_q;
    assign res = res_q;

endmodule

// File: tb/tb_pcpu_core.sv
// Scoreboard bench for pcpu_core: two instances (M=4/255 steps, M=2/10 steps),
// directed GCD/watchdog/stall/wrap/reset runs plus random programs vs an interpreter.
module tb_pcpu_core;

    typedef struct {
        logic [31:0] res;
        bit          err;
        int          lat;
        int          t0;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b1;
    logic [31:0] arg_a = '0, arg_b = '0;

    logic        m_we = 1'b0, m_start = 1'b0;
    logic [3:0]  m_addr = '0;
    logic [12:0] m_wdata = '0;
    logic        m_busy, m_done, m_err;
    logic [31:0] m_res;

    logic        w_we = 1'b0, w_start = 1'b0;
    logic [1:0]  w_addr = '0;
    logic [10:0] w_wdata = '0;
    logic        w_busy, w_done, w_err;
    logic [31:0] w_res;

    logic [15:0] prog_m [16];
    logic [15:0] prog_w [16];
    exp_t        qm[$], qw[$];
    int          cyc = 0;
    int          vectors = 0, miscompares = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pcpu_core #(.P_WIDTH(32), .P_NUM_REGS(4), .P_LOG_MEMSIZE(4), .P_MAX_STEPS(255)) u_m (
        .clk(clk), .rst(rst), .en(en), .pm_we(m_we), .pm_addr(m_addr), .pm_wdata(m_wdata),
        .start(m_start), .arg_a(arg_a), .arg_b(arg_b),
        .busy(m_busy), .done(m_done), .err(m_err), .res(m_res)
    );

    pcpu_core #(.P_WIDTH(32), .P_NUM_REGS(4), .P_LOG_MEMSIZE(2), .P_MAX_STEPS(10)) u_w (
        .clk(clk), .rst(rst), .en(en), .pm_we(w_we), .pm_addr(w_addr), .pm_wdata(w_wdata),
        .start(w_start), .arg_a(arg_a), .arg_b(arg_b),
        .busy(w_busy), .done(w_done), .err(w_err), .res(w_res)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] enc(input int m, input int opc, input int rd, input int ra,
                                        input int rb, input int tgt);
        return 16'((opc << (6 + m)) | (rd << (4 + m)) | (ra << (2 + m)) | (rb << m) | tgt);
    endfunction

    // Instruction-level interpreter; lat = non-HALT instructions executed + 2.
    function automatic void model(input logic [15:0] prog[16], input int m, input int maxs,
                                  input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] res, output bit err, output int lat);
        logic [31:0] r[4];
        int pc = 0, steps = 0, size = 1 << m;
        int ins, opc, rd, ra, rb, tgt;
        r = '{a, b, 32'd0, 32'd0};
        res = '0; err = 1'b0; lat = 0;
        for (int guard = 0; guard < 100000; guard++) begin
            ins = int'(prog[pc]);
            opc = (ins >> (6 + m)) & 7;
            rd  = (ins >> (4 + m)) & 3;
            ra  = (ins >> (2 + m)) & 3;
            rb  = (ins >> m) & 3;
            tgt = ins & (size - 1);
            if (opc == 7 && r[ra] == r[rb] && tgt == pc) begin
                res = r[0]; err = 1'b0; lat = steps + 2; return;
            end
            if (maxs != 0 && steps == maxs) begin
                res = r[0]; err = 1'b1; lat = steps + 2; return;
            end
            case (opc)
                0: r[rd] = r[ra] + r[rb];
                1: r[rd] = r[ra] - r[rb];
                2: r[rd] = r[ra] & r[rb];
                3: r[rd] = r[ra] | r[rb];
                4: r[rd] = r[ra] ^ r[rb];
                5: r[rd] = r[ra] >> 1;
                default: ;
            endcase
            if (opc == 6)      pc = (r[ra] < r[rb]) ? tgt : (pc + 1) % size;
            else if (opc == 7) pc = (r[ra] == r[rb]) ? tgt : (pc + 1) % size;
            else               pc = (pc + 1) % size;
            steps++;
        end
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (m_done) begin
            if (qm.size() == 0) begin
                chk("m_unexpected_done", 1, 0);
            end else begin
                e = qm.pop_front();
                chk("m_res", m_res, e.res);
                chk("m_err", 64'(m_err), 64'(e.err));
                chk("m_latency", 64'(cyc - e.t0), 64'(e.lat));
                chk("m_busy_at_done", 64'(m_busy), 0);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (w_done) begin
            if (qw.size() == 0) begin
                chk("w_unexpected_done", 1, 0);
            end else begin
                e = qw.pop_front();
                chk("w_res", w_res, e.res);
                chk("w_err", 64'(w_err), 64'(e.err));
                chk("w_latency", 64'(cyc - e.t0), 64'(e.lat));
                chk("w_busy_at_done", 64'(w_busy), 0);
            end
        end
    end

    task automatic load(input bit sel);
        int n = sel ? 4 : 16;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (sel) begin w_we = 1'b1; w_addr = 2'(i); w_wdata = prog_w[i][10:0]; end
            else     begin m_we = 1'b1; m_addr = 4'(i); m_wdata = prog_m[i][12:0]; end
        end
        @(negedge clk);
        m_we = 1'b0; w_we = 1'b0;
    endtask

    task automatic run_exp(input bit sel, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] res, input bit err, input int lat,
                           input int stall_len, input bit poke);
        exp_t x;
        @(negedge clk);
        arg_a = a; arg_b = b;
        x.res = res; x.err = err; x.lat = lat + stall_len; x.t0 = cyc;
        if (sel) begin w_start = 1'b1; qw.push_back(x); end
        else     begin m_start = 1'b1; qm.push_back(x); end
        @(negedge clk);
        m_start = 1'b0; w_start = 1'b0;
        chk(sel ? "w_busy_after_start" : "m_busy_after_start", 64'(sel ? w_busy : m_busy), 1);
        chk(sel ? "w_err_cleared" : "m_err_cleared", 64'(sel ? w_err : m_err), 0);
        if (poke) begin
            m_we = 1'b1; m_addr = 4'd0; m_wdata = 13'h1abc; m_start = 1'b1;
            @(negedge clk);
            m_we = 1'b0; m_start = 1'b0;
        end
        if (stall_len > 0) begin
            en = 1'b0;
            repeat (stall_len) @(negedge clk);
            en = 1'b1;
        end
        for (int i = 0; i < 2000 && (sel ? qw.size() : qm.size()) != 0; i++) @(negedge clk);
        if ((sel ? qw.size() : qm.size()) != 0) begin
            chk(sel ? "w_done_timeout" : "m_done_timeout", 1, 0);
            if (sel) qw.delete(); else qm.delete();
        end
    endtask

    task automatic run(input bit sel, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        bit e;
        int lat;
        if (sel) model(prog_w, 2, 10, a, b, r, e, lat);
        else     model(prog_m, 4, 255, a, b, r, e, lat);
        run_exp(sel, a, b, r, e, lat, 0, 1'b0);
    endtask

    initial begin
        logic [31:0] gr;
        bit ge;
        int glat;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("m_reset_busy", 64'(m_busy), 0);
        chk("m_reset_done", 64'(m_done), 0);
        chk("m_reset_err", 64'(m_err), 0);
        chk("m_reset_res", m_res, 0);
        chk("w_reset_busy", 64'(w_busy), 0);
        chk("w_reset_res", w_res, 0);

        for (int i = 0; i < 16; i++) begin prog_m[i] = '0; prog_w[i] = '0; end
        prog_m[0] = enc(4, 7, 0, 0, 1, 6);
        prog_m[1] = enc(4, 6, 0, 0, 1, 4);
        prog_m[2] = enc(4, 1, 0, 0, 1, 0);
        prog_m[3] = enc(4, 7, 0, 2, 2, 0);
        prog_m[4] = enc(4, 1, 1, 1, 0, 0);
        prog_m[5] = enc(4, 7, 0, 2, 2, 0);
        prog_m[6] = enc(4, 7, 0, 2, 2, 6);
        load(0);

        model(prog_m, 4, 255, 32'd48, 32'd18, gr, ge, glat);
        run_exp(0, 32'd48, 32'd18, 32'd6, 1'b0, glat, 0, 1'b0);
        run_exp(0, 32'd48, 32'd18, 32'd6, 1'b0, glat, 5, 1'b0);
        run_exp(0, 32'd48, 32'd18, 32'd6, 1'b0, glat, 0, 1'b1);
        run_exp(0, 32'd48, 32'd18, 32'd6, 1'b0, glat, 0, 1'b0);
        for (int k = 0; k < 6; k++) run(0, 32'($urandom_range(0, 120)), 32'($urandom_range(1, 120)));

        @(negedge clk);
        arg_a = 32'd1000; arg_b = 32'd3; m_start = 1'b1;
        @(negedge clk);
        m_start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("m_rst_busy", 64'(m_busy), 0);
        chk("m_rst_done", 64'(m_done), 0);
        chk("m_rst_res", m_res, 0);
        chk("m_rst_err", 64'(m_err), 0);
        @(negedge clk);
        rst = 1'b0;
        run_exp(0, 32'd48, 32'd18, 32'd6, 1'b0, glat, 0, 1'b0);

        prog_w[0] = enc(2, 7, 0, 2, 2, 1);
        prog_w[1] = enc(2, 7, 0, 2, 2, 0);
        load(1);
        run_exp(1, 32'd7, 32'd9, 32'd7, 1'b1, 12, 0, 1'b0);
        run_exp(1, 32'd5, 32'd5, 32'd5, 1'b1, 12, 0, 1'b0);

        prog_w[0] = enc(2, 0, 0, 0, 1, 0);
        prog_w[1] = enc(2, 4, 2, 2, 2, 0);
        prog_w[2] = enc(2, 4, 2, 2, 2, 0);
        prog_w[3] = enc(2, 6, 0, 2, 0, 0);
        load(1);
        run_exp(1, 32'd0, 32'd1, 32'd3, 1'b1, 12, 0, 1'b0);
        run_exp(1, 32'd0, 32'd0, 32'd0, 1'b1, 12, 0, 1'b0);

        for (int k = 0; k < 12; k++) begin
            for (int i = 0; i < 16; i++) prog_m[i] = 16'($urandom_range(0, 8191));
            load(0);
            run(0, (k % 2) ? $urandom : 32'($urandom_range(0, 15)),
                   (k % 2) ? $urandom : 32'($urandom_range(0, 15)));
        end
        for (int k = 0; k < 12; k++) begin
            for (int i = 0; i < 4; i++) prog_w[i] = 16'($urandom_range(0, 2047));
            load(1);
            run(1, 32'($urandom_range(0, 15)), 32'($urandom_range(0, 15)));
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
